// File: rtl/rf_pkg.sv
// Shared types, default sizes and address-split helpers for the banked register file.
package rf_pkg;

  localparam int unsigned DefDataW   = 32;
  localparam int unsigned DefNumRegs = 64;
  localparam int unsigned DefNumBanks = 4;

  typedef enum logic [0:0] {
    StIdle,
    StConflict
  } state_e;

  // Low address bits pick the bank so consecutive registers land in different banks.
  function automatic int unsigned bank_idx(int unsigned addr, int unsigned num_banks);
    return addr % num_banks;
  endfunction

  function automatic int unsigned row_idx(int unsigned addr, int unsigned num_banks);
    return addr / num_banks;
  endfunction

endpackage

// File: rtl/banked_register_file_if.sv
// Write port, read request handshake and registered read response of the register file.
interface banked_register_file_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 6
);
  logic              WEN;
  logic [ADDR_W-1:0] wsel;
  logic [DATA_W-1:0] wdat;
  logic              req_valid;
  logic              req_ready;
  logic              ren1;
  logic              ren2;
  logic [ADDR_W-1:0] rsel1;
  logic [ADDR_W-1:0] rsel2;
  logic              rsp_valid;
  logic [DATA_W-1:0] rdat1;
  logic [DATA_W-1:0] rdat2;

  modport master (
    output WEN, wsel, wdat, req_valid, ren1, ren2, rsel1, rsel2,
    input  req_ready, rsp_valid, rdat1, rdat2
  );

  modport slave (
    input  WEN, wsel, wdat, req_valid, ren1, ren2, rsel1, rsel2,
    output req_ready, rsp_valid, rdat1, rdat2
  );
endinterface

// File: rtl/rf_bank.sv
// One bank: synchronous write, combinational read with same-cycle write bypass.
module rf_bank #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ROWS   = 16,
  parameter int unsigned ROW_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ROW_W-1:0]  wrow,
  input  logic [DATA_W-1:0] wdat,
  input  logic [ROW_W-1:0]  rrow,
  output logic [DATA_W-1:0] rdat
);

  logic [DATA_W-1:0] mem_q [ROWS];

  // Storage; reset clears every row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ROWS); i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[wrow] <= wdat;
    end
  end

  // A read racing a write to the same row sees the incoming data.
  always_comb begin
    rdat = mem_q[rrow];
    if (we && (wrow == rrow)) rdat = wdat;
  end

endmodule

// File: rtl/banked_register_file.sv
// Multi-bank register file: two read ports, one write port, same-bank conflicts serialised.
module banked_register_file
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned NUM_REGS  = DefNumRegs,
  parameter int unsigned NUM_BANKS = DefNumBanks
) (
  input logic CLK,
  input logic nRST,
  banked_register_file_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(NUM_REGS);
  localparam int unsigned BANK_W = $clog2(NUM_BANKS);
  localparam int unsigned ROWS   = NUM_REGS / NUM_BANKS;
  localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0] hold1_q, hold1_d;
  logic [DATA_W-1:0] rdat1_q, rdat1_d;
  logic [DATA_W-1:0] rdat2_q, rdat2_d;
  logic              rsp_valid_q, rsp_valid_d;

  logic [BANK_W-1:0] bank1, bank2, bank_p, bank_w;
  logic [ROW_W-1:0]  row1, row2, row_p, row_w;
  logic              accept, conflict;
  logic [DATA_W-1:0] port1_dat, port2_dat;

  logic [DATA_W-1:0] rd_dat [NUM_BANKS];
  logic [ROW_W-1:0]  rd_row [NUM_BANKS];

  assign bank1  = BANK_W'(bank_idx(32'(bus.rsel1), NUM_BANKS));
  assign bank2  = BANK_W'(bank_idx(32'(bus.rsel2), NUM_BANKS));
  assign bank_p = BANK_W'(bank_idx(32'(pend_addr_q), NUM_BANKS));
  assign bank_w = BANK_W'(bank_idx(32'(bus.wsel), NUM_BANKS));
  assign row1   = ROW_W'(row_idx(32'(bus.rsel1), NUM_BANKS));
  assign row2   = ROW_W'(row_idx(32'(bus.rsel2), NUM_BANKS));
  assign row_p  = ROW_W'(row_idx(32'(pend_addr_q), NUM_BANKS));
  assign row_w  = ROW_W'(row_idx(32'(bus.wsel), NUM_BANKS));

  for (genvar b = 0; b < int'(NUM_BANKS); b++) begin : g_bank
    // While deferred, only the pending address is read; otherwise an enabled port 1 owns its bank.
    assign rd_row[b] = (state_q == StConflict)              ? row_p :
                       (bus.ren1 && (bank1 == BANK_W'(b)))  ? row1  : row2;

    rf_bank #(
      .DATA_W (DATA_W),
      .ROWS   (ROWS),
      .ROW_W  (ROW_W)
    ) u_bank (
      .clk   (CLK),
      .rst_n (nRST),
      .we    (bus.WEN && (bank_w == BANK_W'(b))),
      .wrow  (row_w),
      .wdat  (bus.wdat),
      .rrow  (rd_row[b]),
      .rdat  (rd_dat[b])
    );
  end

  assign bus.req_ready = (state_q == StIdle);
  assign accept        = bus.req_valid && bus.req_ready;
  assign conflict      = bus.ren1 && bus.ren2 && (bank1 == bank2) && (bus.rsel1 != bus.rsel2);
  assign port1_dat     = bus.ren1 ? rd_dat[bank1] : '0;
  assign port2_dat     = bus.ren2 ? rd_dat[bank2] : '0;

  // Next-state and response data; outputs hold unless a response is produced.
  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    hold1_d     = hold1_q;
    rdat1_d     = rdat1_q;
    rdat2_d     = rdat2_q;
    rsp_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (conflict) begin
            hold1_d     = port1_dat;
            pend_addr_d = bus.rsel2;
            state_d     = StConflict;
          end else begin
            rsp_valid_d = 1'b1;
            rdat1_d     = port1_dat;
            rdat2_d     = port2_dat;
          end
        end
      end
      StConflict: begin
        rsp_valid_d = 1'b1;
        rdat1_d     = hold1_q;
        rdat2_d     = rd_dat[bank_p];
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and response registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= StIdle;
      pend_addr_q <= '0;
      hold1_q     <= '0;
      rdat1_q     <= '0;
      rdat2_q     <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      hold1_q     <= hold1_d;
      rdat1_q     <= rdat1_d;
      rdat2_q     <= rdat2_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rdat1     = rdat1_q;
  assign bus.rdat2     = rdat2_q;

endmodule
